fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
Parametrised hazard and forwarding scoreboard for the in-order pipeline. It replaces the fixed EX/MEM/WB combinational forwarding unit. The block tracks in-flight register writes in a shift-register model of the post-ID stages. From that model it produces per-source forward selects, load-use stalls and a stall-cycle counter. It sits beside the decode stage and drives the RF_big_mux selects, the PC/IF_ID load enable (as the inverse of stall_out) and the CU_mux bubble select.

Parameters:
RW, 4, register address width
NSRC, 3, number of decode source ports (Rn, Rm, Rd-for-store)
DEPTH, 3, number of post-ID stages that can forward (1=EX ... DEPTH=WB)
LOAD_READY, 2, first stage index at which load data is forwardable (2 = MEM output)
PC_REG, 15, register never forwarded or stalled on (read from the PC path)
CNTW, 16, stall counter width
SELW, $clog2(DEPTH+1), derived; forward select width

Ports:
clk  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-low
id_valid  in  1  decode slot holds a real instruction
id_src_addr  in  NSRC*RW  source register numbers, port k at [k*RW +: RW]
id_src_used  in  NSRC  source k is read by this instruction
id_dst_addr  in  RW  destination register (Rd or 14 for BL)
id_dst_we  in  1  instruction writes the register file
id_is_load  in  1  destination data comes from memory
flush  in  1  branch taken; kill the decode-slot instruction
stall_out  out  1  hold PC and IF_ID; insert a bubble into EX
fwd_sel  out  NSRC*SELW  per source: 0=register file, k=stage k result
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- State: DEPTH entries {v, we, ld, addr}. Entry 1 is EX and entry DEPTH is WB.
- Async reset (R=0): all entries invalid, stall_cnt=0. stall_out and fwd_sel then evaluate to 0 for any inputs.
- Outputs are combinational from the current entries plus the ID inputs. Zero-cycle latency; state updates on the rising edge of clk.
- Match rule for source k:
  - Requires id_valid and id_src_used[k] and src != PC_REG.
  - Requires entry j with v & we & addr == src.
  - The lowest j (youngest) wins.
- fwd_sel[k] = winning j, else 0.
- Load-use hazard: the winning entry has ld=1 and j < LOAD_READY. Then stall_out=1 and fwd_sel[k]=0.
- Older matches are never used when a younger match exists, even if the younger one is not ready.
- Advance every edge: entry j+1 <= entry j for j = 1..DEPTH-1, and entry DEPTH retires.
- Entry 1 <= {id_valid & id_dst_we, id_dst_we, id_is_load, id_dst_addr} when stall_out=0 and flush=0. Otherwise entry 1 <= bubble (v=0).
- flush and stall together: flush wins. A bubble is inserted and the stall does not hold older stages, which always advance.
- stall_cnt increments on an edge where stall_out=1 and flush=0. It saturates at 2^CNTW-1 with no wrap.
- Writes to PC_REG are tracked but never matched.
- id_dst_we=0 leaves an invalid entry and cannot cause forwarding.
- Reset mid-operation discards all in-flight entries immediately. This is asynchronous, not at the next edge.
- Unused upper select codes (above DEPTH) are never produced.

Decomposition:
- Shared package holds:
  - the scoreboard entry struct {v, we, ld, addr};
  - the FWD_RF=0 select constant;
  - the PC_REG default;
  - a clog2 helper.
- One sub-module, fwd_src_match. It is instantiated NSRC times and maps one source address plus the entry vector to {sel, hazard}.
- The top level ORs the hazards into stall_out and owns the shift register and counter.

Test Plan:
1. Reset: drive R=0 mid-stream with entries loaded -> stall_out=0, fwd_sel=0, stall_cnt=0 immediately. After R=1, the scoreboard starts empty.
2. ADD R1 then ORR reading R1 on Rn -> fwd_sel[0]=1. The next reader sees 2, then 3, then 0 on successive cycles.
3. LDR R2 then ADD reading R2 on Rm -> stall_out=1 for exactly 1 cycle and stall_cnt=1. The following cycle gives fwd_sel[1]=2 and stall_out=0.
4. ADD R3 (now MEM) and SUB R3 (now EX), then a reader of R3 -> fwd_sel=1, the youngest.
5. Source R15, or id_src_used=0, or producer with id_dst_we=0 -> fwd_sel=0 and stall_out=0.
6. LDR R4 then a reader of R4 with flush=1 in the same cycle -> the bubble enters EX, stall_cnt is unchanged and the LDR still advances to MEM.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types, constants and helpers for the forwarding scoreboard.
package fwd_scoreboard_pkg;

  // Widest register address any instance may use; entry addresses are zero-extended to this.
  localparam int unsigned ADDR_MAXW = 8;

  // Forward select code meaning "take the register file value".
  localparam int unsigned FWD_RF = 0;

  // Register read through the PC path; never forwarded or stalled on.
  localparam int unsigned PC_REG_DEFAULT = 15;

  // One in-flight register write tracked in a post-ID stage.
  typedef struct packed {
    logic                 v;
    logic                 we;
    logic                 ld;
    logic [ADDR_MAXW-1:0] addr;
  } sb_entry_t;

  // Ceiling log2 for deriving select widths at elaboration time.
  function automatic int unsigned clog2_fn(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source lookup: youngest matching in-flight write gives the forward select or a load-use hazard.
module fwd_src_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned RW         = 4,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned PC_REG     = PC_REG_DEFAULT,
  parameter int unsigned SELW       = 2
) (
  input  logic                  src_valid,
  input  logic [RW-1:0]         src_addr,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic [SELW-1:0]       sel_c,
  output logic                  hazard_c
);

  logic                 hit;
  logic                 hit_ld;
  logic [SELW-1:0]      hit_idx;
  logic [ADDR_MAXW-1:0] src_ext;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    hit_ld  = 1'b0;
    hit_idx = SELW'(FWD_RF);
    src_ext = ADDR_MAXW'(src_addr);
    if (src_valid && (src_addr != RW'(PC_REG))) begin
      for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
        if (entries[j].v && entries[j].we && (entries[j].addr == src_ext)) begin
          hit     = 1'b1;
          hit_ld  = entries[j].ld;
          hit_idx = SELW'(j + 1);
        end
      end
    end
    hazard_c = hit && hit_ld && (32'(hit_idx) < LOAD_READY);
    sel_c    = hazard_c ? SELW'(FWD_RF) : hit_idx;
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard and forwarding scoreboard beside decode: tracks in-flight writes, drives forward selects and load-use stalls.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned RW         = 4,
  parameter int unsigned NSRC       = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned PC_REG     = PC_REG_DEFAULT,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned SELW       = clog2_fn(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_src_addr,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [RW-1:0]        id_dst_addr,
  input  logic                 id_dst_we,
  input  logic                 id_is_load,
  input  logic                 flush,
  output logic                 stall_out,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic [CNTW-1:0]      stall_cnt
);

  // Index 0 is EX (stage 1), index DEPTH-1 is WB (stage DEPTH).
  sb_entry_t [DEPTH-1:0] entries_q;
  sb_entry_t [DEPTH-1:0] entries_d;
  logic [CNTW-1:0]       stall_cnt_q;
  logic [CNTW-1:0]       stall_cnt_d;
  logic [NSRC-1:0]       hazard_c;

  // One matcher per decode source port.
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_src_match #(
      .RW        (RW),
      .DEPTH     (DEPTH),
      .LOAD_READY(LOAD_READY),
      .PC_REG    (PC_REG),
      .SELW      (SELW)
    ) u_match (
      .src_valid(id_valid & id_src_used[k]),
      .src_addr (id_src_addr[k*RW +: RW]),
      .entries  (entries_q),
      .sel_c    (fwd_sel[k*SELW +: SELW]),
      .hazard_c (hazard_c[k])
    );
  end

  assign stall_out = |hazard_c;
  assign stall_cnt = stall_cnt_q;

  // Older stages always advance; EX takes the decode instruction unless stalled or flushed.
  always_comb begin
    entries_d = '0;
    for (int j = 1; j < int'(DEPTH); j++) begin
      entries_d[j] = entries_q[j-1];
    end
    if (!stall_out && !flush) begin
      entries_d[0].v    = id_valid & id_dst_we;
      entries_d[0].we   = id_dst_we;
      entries_d[0].ld   = id_is_load;
      entries_d[0].addr = ADDR_MAXW'(id_dst_addr);
    end
  end

  // Saturating count of cycles actually spent stalling (a flush cancels the stall).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_out && !flush && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  // State registers; reset empties the pipeline model immediately.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: vector table plus reset and saturation sequences.
module tb_fwd_scoreboard;

  logic        clk;
  logic        R;
  logic        id_valid;
  logic [11:0] id_src_addr;
  logic [2:0]  id_src_used;
  logic [3:0]  id_dst_addr;
  logic        id_dst_we;
  logic        id_is_load;
  logic        flush;
  logic        stall_out;
  logic [5:0]  fwd_sel;
  logic [15:0] stall_cnt;
  logic        sat_stall_out;
  logic [5:0]  sat_fwd_sel;
  logic [3:0]  sat_stall_cnt;

  fwd_scoreboard dut (
    .clk        (clk),
    .R          (R),
    .id_valid   (id_valid),
    .id_src_addr(id_src_addr),
    .id_src_used(id_src_used),
    .id_dst_addr(id_dst_addr),
    .id_dst_we  (id_dst_we),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall_out  (stall_out),
    .fwd_sel    (fwd_sel),
    .stall_cnt  (stall_cnt)
  );

  // Narrow counter instance to reach saturation quickly.
  fwd_scoreboard #(.CNTW(4)) u_sat (
    .clk        (clk),
    .R          (R),
    .id_valid   (id_valid),
    .id_src_addr(id_src_addr),
    .id_src_used(id_src_used),
    .id_dst_addr(id_dst_addr),
    .id_dst_we  (id_dst_we),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall_out  (sat_stall_out),
    .fwd_sel    (sat_fwd_sel),
    .stall_cnt  (sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [11:0] src;
    logic [2:0]  used;
    logic [3:0]  dst;
    logic        we;
    logic        ld;
    logic        fl;
    logic        exp_stall;
    logic [5:0]  exp_sel;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        exp_stall;
    logic [5:0]  exp_sel;
    logic [15:0] exp_cnt;
    logic        chk_sat;
    logic [3:0]  exp_sat;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  vec_t vt[26];

  function automatic logic [11:0] s3(input int a0, input int a1, input int a2);
    return {4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [5:0] f3(input int s0, input int s1, input int s2);
    return {2'(s2), 2'(s1), 2'(s0)};
  endfunction

  function automatic vec_t mk(input int va, input logic [11:0] s, input int u, input int d,
                              input int we, input int ld, input int fl,
                              input int es, input logic [5:0] esel, input int ec);
    vec_t v;
    v.valid     = 1'(va);
    v.src       = s;
    v.used      = 3'(u);
    v.dst       = 4'(d);
    v.we        = 1'(we);
    v.ld        = 1'(ld);
    v.fl        = 1'(fl);
    v.exp_stall = 1'(es);
    v.exp_sel   = esel;
    v.exp_cnt   = 16'(ec);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    id_valid    = v.valid;
    id_src_addr = v.src;
    id_src_used = v.used;
    id_dst_addr = v.dst;
    id_dst_we   = v.we;
    id_is_load  = v.ld;
    flush       = v.fl;
  endtask

  // Drive one decode cycle, queue its expectation, then compare after settling.
  task automatic step(input vec_t v, input string tag, input logic chk_sat, input logic [3:0] exp_sat);
    exp_t e;
    drive(v);
    e.exp_stall = v.exp_stall;
    e.exp_sel   = v.exp_sel;
    e.exp_cnt   = v.exp_cnt;
    e.chk_sat   = chk_sat;
    e.exp_sat   = exp_sat;
    sbq.push_back(e);
    #1;
    if (sbq.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_stall"}, 32'(stall_out), 32'(e.exp_stall));
      check({tag, "_sel"}, 32'(fwd_sel), 32'(e.exp_sel));
      check({tag, "_cnt"}, 32'(stall_cnt), 32'(e.exp_cnt));
      if (e.chk_sat) begin
        check({tag, "_sat_stall"}, 32'(sat_stall_out), 32'(e.exp_stall));
        check({tag, "_sat_sel"}, 32'(sat_fwd_sel), 32'(e.exp_sel));
        check({tag, "_sat_cnt"}, 32'(sat_stall_cnt), 32'(e.exp_sat));
      end
    end
  endtask

  initial begin
    vec_t v;
    // valid, srcs, used, dst, we, ld, flush | stall, sels, cnt
    vt[0]  = mk(1, s3(5, 6, 0), 3, 1, 1, 0, 0, 0, f3(0, 0, 0), 0);   // ADD R1
    vt[1]  = mk(1, s3(1, 0, 0), 1, 7, 1, 0, 0, 0, f3(1, 0, 0), 0);   // reader R1 from EX
    vt[2]  = mk(1, s3(1, 0, 0), 1, 0, 0, 0, 0, 0, f3(2, 0, 0), 0);   // from MEM
    vt[3]  = mk(1, s3(1, 0, 0), 1, 0, 0, 0, 0, 0, f3(3, 0, 0), 0);   // from WB
    vt[4]  = mk(1, s3(1, 0, 0), 1, 0, 0, 0, 0, 0, f3(0, 0, 0), 0);   // retired
    vt[5]  = mk(1, s3(8, 0, 0), 1, 2, 1, 1, 0, 0, f3(0, 0, 0), 0);   // LDR R2
    vt[6]  = mk(1, s3(0, 2, 0), 2, 9, 1, 0, 0, 1, f3(0, 0, 0), 0);   // load-use stall
    vt[7]  = mk(1, s3(0, 2, 0), 2, 9, 1, 0, 0, 0, f3(0, 2, 0), 1);   // released, MEM fwd
    vt[8]  = mk(1, s3(0, 0, 0), 0, 3, 1, 0, 0, 0, f3(0, 0, 0), 1);   // ADD R3
    vt[9]  = mk(1, s3(0, 0, 0), 0, 3, 1, 0, 0, 0, f3(0, 0, 0), 1);   // SUB R3
    vt[10] = mk(1, s3(9, 0, 3), 5, 0, 0, 0, 0, 0, f3(3, 0, 1), 1);   // youngest R3, R9 in WB
    vt[11] = mk(1, s3(3, 3, 0), 3, 0, 0, 0, 0, 0, f3(2, 2, 0), 1);   // R3 on two ports
    vt[12] = mk(1, s3(15, 3, 0), 1, 15, 1, 0, 0, 0, f3(0, 0, 0), 1); // PC src, unused src1
    vt[13] = mk(1, s3(15, 0, 0), 1, 5, 0, 1, 0, 0, f3(0, 0, 0), 1);  // PC write not matched
    vt[14] = mk(1, s3(5, 15, 0), 3, 0, 0, 0, 0, 0, f3(0, 0, 0), 1);  // we=0 load not tracked
    vt[15] = mk(0, s3(0, 0, 0), 0, 6, 1, 1, 0, 0, f3(0, 0, 0), 1);   // invalid slot
    vt[16] = mk(1, s3(6, 0, 0), 1, 0, 0, 0, 0, 0, f3(0, 0, 0), 1);   // no fwd from invalid
    vt[17] = mk(1, s3(0, 0, 0), 0, 4, 1, 1, 0, 0, f3(0, 0, 0), 1);   // LDR R4
    vt[18] = mk(1, s3(4, 0, 0), 1, 0, 0, 0, 1, 1, f3(0, 0, 0), 1);   // stall + flush
    vt[19] = mk(1, s3(4, 0, 0), 1, 0, 0, 0, 0, 0, f3(2, 0, 0), 1);   // LDR reached MEM
    vt[20] = mk(1, s3(0, 0, 0), 0, 10, 1, 0, 0, 0, f3(0, 0, 0), 1);  // ADD R10
    vt[21] = mk(1, s3(0, 0, 0), 0, 10, 1, 1, 0, 0, f3(0, 0, 0), 1);  // LDR R10
    vt[22] = mk(1, s3(10, 0, 0), 1, 0, 0, 0, 0, 1, f3(0, 0, 0), 1);  // younger load wins
    vt[23] = mk(1, s3(10, 0, 0), 1, 0, 0, 0, 0, 0, f3(2, 0, 0), 2);
    vt[24] = mk(1, s3(0, 0, 0), 0, 11, 1, 0, 1, 0, f3(0, 0, 0), 2);  // flushed ADD R11
    vt[25] = mk(1, s3(11, 0, 0), 1, 0, 0, 0, 0, 0, f3(0, 0, 0), 2);  // never entered

    R = 1'b0;
    id_valid = 1'b0; id_src_addr = '0; id_src_used = '0;
    id_dst_addr = '0; id_dst_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    #2;
    check("reset_stall", 32'(stall_out), 0);
    check("reset_sel", 32'(fwd_sel), 0);
    check("reset_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    R = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(vt[i], $sformatf("vec%0d", i), 1'b0, 4'd0);
    end

    // Reset mid-stream with a load in flight and a stall showing.
    step(mk(1, s3(0, 0, 0), 0, 12, 1, 1, 0, 0, f3(0, 0, 0), 2), "ldr_r12", 1'b0, 4'd0);
    drive(mk(1, s3(12, 0, 0), 1, 0, 0, 0, 0, 0, f3(0, 0, 0), 0));
    #1;
    check("pre_rst_stall", 32'(stall_out), 1);
    #1;
    R = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall_out), 0);
    check("mid_rst_sel", 32'(fwd_sel), 0);
    check("mid_rst_cnt", 32'(stall_cnt), 0);
    check("mid_rst_sat_cnt", 32'(sat_stall_cnt), 0);
    @(negedge clk);
    R = 1'b1;
    step(mk(1, s3(12, 0, 0), 1, 0, 0, 0, 0, 0, f3(0, 0, 0), 0), "post_rst", 1'b1, 4'd0);

    // Load that reads its own destination: stalls every other cycle; narrow counter saturates.
    for (int i = 0; i < 40; i++) begin
      int n;
      n = i / 2;
      v = mk(1, s3(13, 0, 0), 1, 13, 1, 1, 0, i % 2,
             f3(((i % 2) == 0 && i > 0) ? 2 : 0, 0, 0), n);
      step(v, $sformatf("sat%0d", i), 1'b1, 4'((n > 15) ? 15 : n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
